// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// datapath select codes, condition codes and the per-state control decode.
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [1:0] IMM8  = 2'b00;
    localparam logic [1:0] IMM12 = 2'b01;
    localparam logic [1:0] BR24  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;

    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       regw;
        logic       memw;
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
    } ctrl_t;

    // Raw (ungated) controls for a state; unknown encodings decode to all-zero.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURES;
            end
            S_DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURES;
            end
            S_MEMADR: c.alu_src_b = SRCB_IMM;
            S_MEMRD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.regw       = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src = 1'b1;
                c.memw    = 1'b1;
            end
            S_EXECR: c.alu_op = 1'b1;
            S_EXECI: begin
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = 1'b1;
            end
            S_ALUWB: c.regw = 1'b1;
            S_BRANCH: begin
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALURES;
                c.branch     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs of the controller.
interface multicycle_controller_if;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;

    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_control;

    modport master (
        output cond, op, funct, rd, alu_flags,
        input  pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control
    );

    modport slave (
        input  cond, op, funct, rd, alu_flags,
        output pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control
    );

endinterface

// File: rtl/multicycle_controller_cond_logic.sv
// NZCV flags register, ARM condition evaluation and the per-instruction
// condition-pass register captured at the end of DECODE.
module cond_logic
    import controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_en,
    input  logic [1:0] flag_w,
    output logic       cond_ex_q
);

    logic [3:0] flags;
    logic       n, z, c, v;
    logic       cond_ex;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            CC_EQ: cond_ex = z;
            CC_NE: cond_ex = ~z;
            CC_CS: cond_ex = c;
            CC_CC: cond_ex = ~c;
            CC_MI: cond_ex = n;
            CC_PL: cond_ex = ~n;
            CC_VS: cond_ex = v;
            CC_VC: cond_ex = ~v;
            CC_HI: cond_ex = c & ~z;
            CC_LS: cond_ex = ~c | z;
            CC_GE: cond_ex = (n == v);
            CC_LT: cond_ex = (n != v);
            CC_GT: cond_ex = ~z & (n == v);
            CC_LE: cond_ex = z | (n != v);
            CC_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // flag_w[1] writes N,Z; flag_w[0] writes C,V (arithmetic ops only).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (cond_en)   cond_ex_q   <= cond_ex;
            if (flag_w[1]) flags[3:2]  <= alu_flags[3:2];
            if (flag_w[0]) flags[1:0]  <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: main FSM with registered raw controls,
// instruction decode and condition-gated write enables.
module multicycle_controller
    import controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.slave  bus
);

    state_t     state, state_nxt;
    ctrl_t      ctrl;
    logic       cond_ex_q;
    logic       pcs;
    logic [1:0] flag_w;
    logic [1:0] alu_control;

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    2'b00:   state_nxt = bus.funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = bus.funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_nxt = S_ALUWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Controls are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            ctrl  <= state_ctrl(S_FETCH);
        end else begin
            state <= state_nxt;
            ctrl  <= state_ctrl(state_nxt);
        end
    end

    always_comb begin
        alu_control = ALU_ADD;
        if (ctrl.alu_op) begin
            case (bus.funct[4:1])
                4'b0100: alu_control = ALU_ADD;
                4'b0010: alu_control = ALU_SUB;
                4'b0000: alu_control = ALU_AND;
                4'b1100: alu_control = ALU_ORR;
                default: alu_control = ALU_ADD;
            endcase
        end
    end

    assign flag_w[1] = ctrl.alu_op & bus.funct[0] & cond_ex_q;
    assign flag_w[0] = flag_w[1] & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));

    cond_logic u_cond (
        .clk       (clk),
        .rst       (rst),
        .cond      (bus.cond),
        .alu_flags (bus.alu_flags),
        .cond_en   (state == S_DECODE),
        .flag_w    (flag_w),
        .cond_ex_q (cond_ex_q)
    );

    assign pcs = ctrl.branch | (ctrl.regw & (bus.rd == 4'hF));

    // Enables are masked by rst so nothing can write while reset is held.
    assign bus.pc_write    = rst & (ctrl.next_pc | (pcs & cond_ex_q));
    assign bus.mem_write   = rst & ctrl.memw & cond_ex_q;
    assign bus.reg_write   = rst & ctrl.regw & cond_ex_q;
    assign bus.ir_write    = rst & ctrl.ir_write;
    assign bus.adr_src     = ctrl.adr_src;
    assign bus.alu_src_a   = ctrl.alu_src_a;
    assign bus.alu_src_b   = ctrl.alu_src_b;
    assign bus.result_src  = ctrl.result_src;
    assign bus.imm_src     = bus.op;
    assign bus.reg_src     = {bus.op == 2'b01, bus.op == 2'b10};
    assign bus.alu_control = alu_control;

endmodule
